// File: rtl/v_issue_scheduler_pkg.sv
// Shared definitions for the vector issue scheduler.
//   - RVV major opcodes, funct3 categories and memory addressing modes (mop)
//   - issue-class bit indices used on the one-hot V_CU valid/ready vectors
//   - queue entry layout (instruction plus its two scalar operands)
package v_issue_scheduler_pkg;

  localparam logic [6:0] v_st_opcode    = 7'b0100111;
  localparam logic [6:0] v_ld_opcode    = 7'b0000111;
  localparam logic [6:0] v_arith_opcode = 7'b1010111;

  localparam logic [2:0] OPIVV = 3'b000;
  localparam logic [2:0] OPFVV = 3'b001;
  localparam logic [2:0] OPMVV = 3'b010;
  localparam logic [2:0] OPIVI = 3'b011;
  localparam logic [2:0] OPIVX = 3'b100;
  localparam logic [2:0] OPFVF = 3'b101;
  localparam logic [2:0] OPMVX = 3'b110;
  localparam logic [2:0] OPCFG = 3'b111;

  localparam logic [1:0] unit_stride   = 2'b00;
  localparam logic [1:0] idx_unordered = 2'b01;
  localparam logic [1:0] strided       = 2'b10;
  localparam logic [1:0] idx_ordered   = 2'b11;

  // Bit position of each issue class in instr_vld_o / instr_rdy_i.
  typedef enum logic [3:0] {
    CLS_STORE     = 4'd0,
    CLS_STORE_IDX = 4'd1,
    CLS_LOAD      = 4'd2,
    CLS_LOAD_IDX  = 4'd3,
    CLS_OPIVV     = 4'd4,
    CLS_OPIVI     = 4'd5,
    CLS_OPIVX     = 4'd6,
    CLS_OPMVV     = 4'd7,
    CLS_OPMVV_101 = 4'd8,
    CLS_OPMVX     = 4'd9,
    CLS_OPMVX_101 = 4'd10,
    CLS_OPCFG     = 4'd11
  } v_class_e;

  localparam int unsigned NUM_CLASSES = 12;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } v_entry_t;

endpackage

// File: rtl/v_sched_fifo.sv
// Generic synchronous FIFO with synchronous flush.
//   clk, rstn      clock / asynchronous active-low reset (control state only)
//   flush_i        empties the FIFO at the clock edge; a same-cycle push is dropped
//   push_i/wdata_i write request (ignored while full)
//   pop_i          read request (ignored while empty)
//   rdata_o        entry at the head (registered storage, no bypass)
//   full_o/empty_o occupancy flags from the count register
module v_sched_fifo #(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; empty_o guards every consumer of rdata_o.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/v_issue_scheduler.sv
// Vector issue scheduler: buffers vector instructions with rs1/rs2, decodes
// the head into a one-hot issue class and hands it to V_CU (and M_CU for
// loads/stores).
//   clk, rstn                      clock / asynchronous active-low reset
//   flush_i                        drop all queued entries
//   vector_vld_i/vector_rdy_o      scalar-core push handshake
//   vector_instr_i, rs1_i, rs2_i   pushed instruction and operands
//   instr_vld_o/instr_rdy_i        one-hot per-class issue handshake to V_CU
//   vector_instr_o, rs1_o, rs2_o   head entry (zero while empty)
//   ld_vld_o/ld_rdy_i              load handshake to M_CU
//   ld_buffered_i                  one outstanding load finished buffering
//   st_vld_o/st_rdy_i              store handshake to M_CU
//   illegal_o                      head dropped as undecodable
//   outst_ld_o                     loads issued but not yet buffered
module v_issue_scheduler
  import v_issue_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned NUM_UNITS    = 12,
  parameter int unsigned MAX_OUTST_LD = 4
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              flush_i,
  input  logic                              vector_vld_i,
  input  logic [31:0]                       vector_instr_i,
  input  logic [31:0]                       rs1_i,
  input  logic [31:0]                       rs2_i,
  output logic                              vector_rdy_o,
  output logic [NUM_UNITS-1:0]              instr_vld_o,
  input  logic [NUM_UNITS-1:0]              instr_rdy_i,
  output logic [31:0]                       vector_instr_o,
  output logic [31:0]                       rs1_o,
  output logic [31:0]                       rs2_o,
  output logic                              ld_vld_o,
  input  logic                              ld_rdy_i,
  input  logic                              ld_buffered_i,
  output logic                              st_vld_o,
  input  logic                              st_rdy_i,
  output logic                              illegal_o,
  output logic [$clog2(MAX_OUTST_LD+1)-1:0] outst_ld_o
);

  localparam int unsigned OUTST_W = $clog2(MAX_OUTST_LD + 1);

  // Counter update: a buffered pulse with nothing outstanding is ignored.
  function automatic logic [OUTST_W-1:0] outst_next(input logic [OUTST_W-1:0] cnt,
                                                   input logic inc, input logic dec);
    logic dec_eff;
    dec_eff = dec && (cnt != '0);
    if (inc && !dec_eff)      return cnt + OUTST_W'(1);
    else if (dec_eff && !inc) return cnt - OUTST_W'(1);
    else                      return cnt;
  endfunction

  v_entry_t            entry_in, head;
  logic                fifo_full, fifo_empty, pop;
  v_class_e            cls;
  logic                is_ld, is_st, head_illegal;
  logic                ld_block, issue_ok, fire, ld_fire;
  logic [OUTST_W-1:0]  outst_q, outst_d;

  assign entry_in = '{instr: vector_instr_i, rs1: rs1_i, rs2: rs2_i};

  v_sched_fifo #(
    .DATA_W ($bits(v_entry_t)),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush_i (flush_i),
    .push_i  (vector_vld_i),
    .pop_i   (pop),
    .wdata_i (entry_in),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Readiness depends only on occupancy, so a full FIFO refuses a push even
  // when the head pops in the same cycle.
  assign vector_rdy_o   = !fifo_full;
  assign vector_instr_o = fifo_empty ? '0 : head.instr;
  assign rs1_o          = fifo_empty ? '0 : head.rs1;
  assign rs2_o          = fifo_empty ? '0 : head.rs2;

  // Head decode
  always_comb begin
    cls          = CLS_OPIVV;
    is_ld        = 1'b0;
    is_st        = 1'b0;
    head_illegal = 1'b0;
    if (!fifo_empty) begin
      case (head.instr[6:0])
        v_st_opcode: begin
          is_st = 1'b1;
          case (head.instr[27:26])
            unit_stride, strided:       cls = CLS_STORE;
            idx_unordered, idx_ordered: cls = CLS_STORE_IDX;
            default:                    cls = CLS_STORE;
          endcase
        end
        v_ld_opcode: begin
          is_ld = 1'b1;
          case (head.instr[27:26])
            unit_stride, strided:       cls = CLS_LOAD;
            idx_unordered, idx_ordered: cls = CLS_LOAD_IDX;
            default:                    cls = CLS_LOAD;
          endcase
        end
        v_arith_opcode: begin
          case (head.instr[14:12])
            OPIVV:   cls = CLS_OPIVV;
            OPIVI:   cls = CLS_OPIVI;
            OPIVX:   cls = CLS_OPIVX;
            OPMVV:   cls = (head.instr[31:29] == 3'b101) ? CLS_OPMVV_101 : CLS_OPMVV;
            OPMVX:   cls = (head.instr[31:29] == 3'b101) ? CLS_OPMVX_101 : CLS_OPMVX;
            OPCFG:   cls = CLS_OPCFG;
            default: head_illegal = 1'b1;   // OPFVV / OPFVF: no FP unit behind this scheduler
          endcase
        end
        default: head_illegal = 1'b1;
      endcase
    end
  end

  // Issue: valids are built from state and flush only, never from a ready.
  assign ld_block = is_ld && (outst_q == OUTST_W'(MAX_OUTST_LD));
  assign issue_ok = !fifo_empty && !head_illegal && !flush_i && !ld_block;

  always_comb begin
    instr_vld_o = '0;
    if (issue_ok) instr_vld_o = NUM_UNITS'(1) << cls;
  end

  assign ld_vld_o  = issue_ok && is_ld;
  assign st_vld_o  = issue_ok && is_st;
  assign illegal_o = head_illegal && !flush_i;

  // Memory classes need V_CU and M_CU to accept in the same cycle.
  assign fire    = (|(instr_vld_o & instr_rdy_i)) && (!is_ld || ld_rdy_i) && (!is_st || st_rdy_i);
  assign ld_fire = fire && is_ld;
  assign pop     = fire || illegal_o;

  // Outstanding-load counter
  assign outst_d    = outst_next(outst_q, ld_fire, ld_buffered_i);
  assign outst_ld_o = outst_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) outst_q <= '0;
    else       outst_q <= outst_d;
  end

endmodule

// File: tb/tb_v_issue_scheduler.sv
module tb_v_issue_scheduler;

  localparam int NU = 12;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush_i = 1'b0;
  logic          vector_vld_i = 1'b0;
  logic [31:0]   vector_instr_i = '0;
  logic [31:0]   rs1_i = '0;
  logic [31:0]   rs2_i = '0;
  logic [NU-1:0] instr_rdy_i = '0;
  logic          ld_rdy_i = 1'b0;
  logic          ld_buffered_i = 1'b0;
  logic          st_rdy_i = 1'b0;
  logic          vector_rdy_o;
  logic [NU-1:0] instr_vld_o;
  logic [31:0]   vector_instr_o, rs1_o, rs2_o;
  logic          ld_vld_o, st_vld_o, illegal_o;
  logic [1:0]    outst_ld_o;

  v_issue_scheduler #(.DEPTH(4), .NUM_UNITS(NU), .MAX_OUTST_LD(2)) dut (
    .clk(clk), .rstn(rstn), .flush_i(flush_i),
    .vector_vld_i(vector_vld_i), .vector_instr_i(vector_instr_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .vector_rdy_o(vector_rdy_o),
    .instr_vld_o(instr_vld_o), .instr_rdy_i(instr_rdy_i),
    .vector_instr_o(vector_instr_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .ld_vld_o(ld_vld_o), .ld_rdy_i(ld_rdy_i), .ld_buffered_i(ld_buffered_i),
    .st_vld_o(st_vld_o), .st_rdy_i(st_rdy_i), .illegal_o(illegal_o),
    .outst_ld_o(outst_ld_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0]   instr;
    logic [31:0]   rs1;
    logic [31:0]   rs2;
    logic [NU-1:0] vld;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] arith(input logic [5:0] f6, input logic [2:0] f3);
    return {f6, 1'b1, 5'd2, 5'd1, f3, 5'd3, 7'b1010111};
  endfunction

  function automatic logic [31:0] vmem(input logic [6:0] opc, input logic [1:0] mop);
    return {3'b000, 1'b0, mop, 1'b1, 5'd0, 5'd10, 3'b111, 5'd4, opc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one push offer; entries expected to be accepted go on the scoreboard.
  task automatic offer(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [NU-1:0] v, input bit accept);
    vector_vld_i   = 1'b1;
    vector_instr_i = ins;
    rs1_i          = r1;
    rs2_i          = r2;
    if (accept) sb.push_back('{ins, r1, r2, v});
  endtask

  task automatic test_reset();
    exp_t e;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({vector_rdy_o, instr_vld_o, ld_vld_o, st_vld_o, illegal_o, outst_ld_o} !== {1'b1, 12'b0, 1'b0, 1'b0, 1'b0, 2'b0}) begin
      errors++;
      $display("FAIL reset_ctrl: rdy=%b vld=%b ld=%b st=%b ill=%b outst=%0d, need rdy=1 rest 0", vector_rdy_o, instr_vld_o, ld_vld_o, st_vld_o, illegal_o, outst_ld_o);
    end
    checks++;
    if ({vector_instr_o, rs1_o, rs2_o} !== 96'b0) begin
      errors++;
      $display("FAIL reset_data: instr=%h rs1=%h rs2=%h, need all 0", vector_instr_o, rs1_o, rs2_o);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (vector_rdy_o !== 1'b1 || instr_vld_o !== '0 || outst_ld_o !== 2'd0) begin
      errors++;
      $display("FAIL after_reset: rdy=%b vld=%b outst=%0d, need 1/0/0", vector_rdy_o, instr_vld_o, outst_ld_o);
    end
    tick();
  endtask

  task automatic test_single();
    exp_t e;
    instr_rdy_i = '1;
    offer(arith(6'b000000, 3'b000), 32'h11, 32'h22, 12'h010, 1'b1);
    @(negedge clk);
    checks++;
    if (instr_vld_o !== '0) begin
      errors++;
      $display("FAIL single_latency: instr_vld_o=%b in push cycle, need 0", instr_vld_o);
    end
    tick();
    vector_vld_i = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (instr_vld_o !== e.vld || vector_instr_o !== e.instr || rs1_o !== e.rs1 || rs2_o !== e.rs2) begin
      errors++;
      $display("FAIL single_issue: vld=%b instr=%h rs1=%h rs2=%h, need %b %h %h %h", instr_vld_o, vector_instr_o, rs1_o, rs2_o, e.vld, e.instr, e.rs1, e.rs2);
    end
    tick();
    @(negedge clk);
    checks++;
    if (instr_vld_o !== '0 || vector_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_popped: vld=%b rdy=%b, need 0/1", instr_vld_o, vector_rdy_o);
    end
    tick();
  endtask

  task automatic test_full_drain();
    exp_t        e;
    logic [31:0] ins [4];
    logic [NU-1:0] cls [4];
    ins[0] = arith(6'b000000, 3'b100);        cls[0] = 12'h040;
    ins[1] = vmem(7'b0100111, 2'b11);         cls[1] = 12'h002;
    ins[2] = arith(6'b000000, 3'b010);        cls[2] = 12'h080;
    ins[3] = arith(6'b000000, 3'b111);        cls[3] = 12'h800;
    instr_rdy_i = '0;
    for (int i = 0; i < 4; i++) begin
      offer(ins[i], 32'h100 + i, 32'h200 + i, cls[i], 1'b1);
      @(negedge clk);
      checks++;
      if (vector_rdy_o !== 1'b1) begin
        errors++;
        $display("FAIL fill_rdy[%0d]: vector_rdy_o=%b, need 1", i, vector_rdy_o);
      end
      tick();
    end
    offer(arith(6'b000000, 3'b000), 32'hDEAD, 32'hBEEF, 12'h010, 1'b0);
    @(negedge clk);
    checks++;
    if (vector_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL full_rdy: vector_rdy_o=%b with 4 entries, need 0", vector_rdy_o);
    end
    tick();
    vector_vld_i = 1'b0;
    instr_rdy_i  = '1;
    st_rdy_i     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL drain[%0d]: vld=%b with empty scoreboard, need none", i, instr_vld_o);
      end else begin
        e = sb.pop_front();
        if (instr_vld_o !== e.vld || vector_instr_o !== e.instr || rs1_o !== e.rs1 || rs2_o !== e.rs2) begin
          errors++;
          $display("FAIL drain[%0d]: vld=%b instr=%h rs1=%h rs2=%h, need %b %h %h %h", i, instr_vld_o, vector_instr_o, rs1_o, rs2_o, e.vld, e.instr, e.rs1, e.rs2);
        end
      end
      tick();
    end
    st_rdy_i = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_vld_o !== '0 || vector_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: vld=%b rdy=%b, need 0/1 (refused push must not appear)", instr_vld_o, vector_rdy_o);
    end
    tick();
  endtask

  task automatic test_load_throttle();
    exp_t e;
    instr_rdy_i = '1;
    ld_rdy_i    = 1'b1;
    for (int c = 0; c < 7; c++) begin
      vector_vld_i  = 1'b0;
      ld_buffered_i = 1'b0;
      if (c < 3) offer(vmem(7'b0000111, 2'b00), 32'h300 + c, 32'h400 + c, 12'h004, 1'b1);
      if (c == 4) ld_buffered_i = 1'b1;
      @(negedge clk);
      if (c == 1 || c == 2 || c == 5) begin
        e = sb.pop_front();
        checks++;
        if (ld_vld_o !== 1'b1 || instr_vld_o !== e.vld || rs1_o !== e.rs1 || outst_ld_o !== ((c == 2) ? 2'd1 : (c == 1) ? 2'd0 : 2'd1)) begin
          errors++;
          $display("FAIL load_issue c%0d: ld_vld=%b vld=%b rs1=%h outst=%0d, need ld_vld=1 vld=%b rs1=%h", c, ld_vld_o, instr_vld_o, rs1_o, outst_ld_o, e.vld, e.rs1);
        end
      end else if (c == 3 || c == 4) begin
        checks++;
        if (ld_vld_o !== 1'b0 || instr_vld_o !== '0 || outst_ld_o !== 2'd2) begin
          errors++;
          $display("FAIL load_throttle c%0d: ld_vld=%b vld=%b outst=%0d, need 0/0/2", c, ld_vld_o, instr_vld_o, outst_ld_o);
        end
      end else if (c == 6) begin
        checks++;
        if (outst_ld_o !== 2'd2 || instr_vld_o !== '0) begin
          errors++;
          $display("FAIL load_final: outst=%0d vld=%b, need 2/0", outst_ld_o, instr_vld_o);
        end
      end
      tick();
    end
    vector_vld_i  = 1'b0;
    ld_buffered_i = 1'b0;
    ld_rdy_i      = 1'b0;
  endtask

  task automatic test_store_hold();
    exp_t        e;
    logic [31:0] st_ins;
    st_ins      = vmem(7'b0100111, 2'b00);
    instr_rdy_i = 12'h001;
    st_rdy_i    = 1'b0;
    offer(st_ins, 32'h500, 32'h600, 12'h001, 1'b1);
    @(negedge clk);
    tick();
    vector_vld_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (st_vld_o !== 1'b1 || instr_vld_o !== 12'h001 || vector_instr_o !== st_ins) begin
        errors++;
        $display("FAIL store_hold[%0d]: st_vld=%b vld=%b instr=%h, need 1 %b %h", k, st_vld_o, instr_vld_o, vector_instr_o, 12'h001, st_ins);
      end
      tick();
    end
    st_rdy_i = 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (st_vld_o !== 1'b1 || instr_vld_o !== e.vld || rs2_o !== e.rs2) begin
      errors++;
      $display("FAIL store_fire: st_vld=%b vld=%b rs2=%h, need 1 %b %h", st_vld_o, instr_vld_o, rs2_o, e.vld, e.rs2);
    end
    tick();
    st_rdy_i = 1'b0;
    @(negedge clk);
    checks++;
    if (st_vld_o !== 1'b0 || instr_vld_o !== '0) begin
      errors++;
      $display("FAIL store_popped: st_vld=%b vld=%b, need 0/0", st_vld_o, instr_vld_o);
    end
    tick();
  endtask

  task automatic test_illegal();
    exp_t e;
    int   pulses;
    pulses      = 0;
    instr_rdy_i = '1;
    offer(arith(6'b000000, 3'b001), 32'h700, 32'h701, '0, 1'b0);
    @(negedge clk);
    if (illegal_o === 1'b1) pulses++;
    tick();
    offer(arith(6'b101001, 3'b110), 32'h800, 32'h801, 12'h400, 1'b1);
    @(negedge clk);
    if (illegal_o === 1'b1) pulses++;
    checks++;
    if (illegal_o !== 1'b1 || instr_vld_o !== '0) begin
      errors++;
      $display("FAIL illegal_head: illegal_o=%b vld=%b, need 1/0", illegal_o, instr_vld_o);
    end
    tick();
    vector_vld_i = 1'b0;
    @(negedge clk);
    if (illegal_o === 1'b1) pulses++;
    e = sb.pop_front();
    checks++;
    if (instr_vld_o !== e.vld || rs1_o !== e.rs1) begin
      errors++;
      $display("FAIL mvx_101: vld=%b rs1=%h, need %b %h", instr_vld_o, rs1_o, e.vld, e.rs1);
    end
    tick();
    @(negedge clk);
    if (illegal_o === 1'b1) pulses++;
    checks++;
    if (pulses != 1 || instr_vld_o !== '0) begin
      errors++;
      $display("FAIL illegal_pulses: pulses=%0d vld=%b, need 1/0", pulses, instr_vld_o);
    end
    tick();
  endtask

  task automatic test_flush();
    exp_t e;
    instr_rdy_i = '0;
    for (int i = 0; i < 3; i++) begin
      offer(arith(6'b000000, 3'b110), 32'h900 + i, 32'h0, 12'h200, 1'b0);
      tick();
    end
    offer(arith(6'b000000, 3'b000), 32'hA00, 32'h0, 12'h010, 1'b0);
    flush_i     = 1'b1;
    instr_rdy_i = '1;
    @(negedge clk);
    checks++;
    if (instr_vld_o !== '0 || illegal_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: vld=%b illegal=%b, need 0/0", instr_vld_o, illegal_o);
    end
    tick();
    flush_i      = 1'b0;
    vector_vld_i = 1'b0;
    @(negedge clk);
    checks++;
    if (vector_rdy_o !== 1'b1 || instr_vld_o !== '0 || vector_instr_o !== 32'h0 || outst_ld_o !== 2'd2) begin
      errors++;
      $display("FAIL flush_after: rdy=%b vld=%b instr=%h outst=%0d, need 1/0/0/2", vector_rdy_o, instr_vld_o, vector_instr_o, outst_ld_o);
    end
    tick();
    offer(arith(6'b000000, 3'b011), 32'hB00, 32'hB01, 12'h020, 1'b1);
    @(negedge clk);
    tick();
    vector_vld_i = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (instr_vld_o !== e.vld || rs1_o !== e.rs1 || rs2_o !== e.rs2) begin
      errors++;
      $display("FAIL flush_repush: vld=%b rs1=%h rs2=%h, need %b %h %h", instr_vld_o, rs1_o, rs2_o, e.vld, e.rs1, e.rs2);
    end
    tick();
  endtask

  task automatic test_async_reset();
    instr_rdy_i = '0;
    offer(arith(6'b000000, 3'b000), 32'hC00, 32'hC01, 12'h010, 1'b0);
    tick();
    offer(arith(6'b000000, 3'b100), 32'hC10, 32'hC11, 12'h040, 1'b0);
    tick();
    vector_vld_i = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_vld_o !== 12'h010 || outst_ld_o !== 2'd2) begin
      errors++;
      $display("FAIL pre_reset: vld=%b outst=%0d, need %b/2", instr_vld_o, outst_ld_o, 12'h010);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (vector_rdy_o !== 1'b1 || instr_vld_o !== '0 || outst_ld_o !== 2'd0 || vector_instr_o !== 32'h0 || rs1_o !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b vld=%b outst=%0d instr=%h rs1=%h, need 1/0/0/0/0", vector_rdy_o, instr_vld_o, outst_ld_o, vector_instr_o, rs1_o);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_vld_o !== '0 || vector_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL post_async_reset: vld=%b rdy=%b, need 0/1", instr_vld_o, vector_rdy_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_drain();
    test_load_throttle();
    test_store_hold();
    test_illegal();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

endmodule
